// File: rtl/irq_source_ctrl_pkg.sv
// rtl/irq_source_ctrl_pkg.sv - shared constants for the external interrupt controller
package irq_source_ctrl_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_SERVICE  = 2'd3;

  localparam logic [1:0] REG_MASK   = 2'd0;
  localparam logic [1:0] REG_PEND   = 2'd1;
  localparam logic [1:0] REG_SWINT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int STAT_ERR_BIT   = 8;
  localparam int STAT_STATE_LSB = 4;
  localparam int STAT_ID_LSB    = 0;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest set index wins
module irq_prio_enc #(
  parameter int N_IN = 9,
  parameter int ID_W = 4
) (
  input  logic [N_IN-1:0] req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_source_ctrl.sv
// rtl/irq_source_ctrl.sv - external interrupt controller feeding cp0 ir_in/int_cause
module irq_source_ctrl
  import irq_source_ctrl_pkg::*;
#(
  parameter int N_SRC       = 8,
  parameter int ID_W        = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             ir_out,
  output logic             int_cause,
  output logic [ID_W-1:0]  irq_id,
  input  logic             cp0_jump,
  input  logic             cp0_eret
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [N_SRC-1:0] sync1, sync2, sync3;
  logic [N_SRC-1:0] rise, mask, pend, ack_clr, w1c;
  logic             swpend, err;
  logic [1:0]       state;
  logic [CNT_W-1:0] ack_cnt;
  logic             enc_valid;
  logic [ID_W-1:0]  enc_id;
  logic             ack, timeout, serving_sw, sw_set;

  assign rise       = sync2 & ~sync3;
  assign ack        = (state == ST_WAIT_ACK) && cp0_jump;
  assign timeout    = (state == ST_WAIT_ACK) && !cp0_jump && (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign serving_sw = (irq_id == ID_W'(N_SRC));
  assign w1c        = (reg_we && reg_addr == REG_PEND) ? reg_wdata[N_SRC-1:0] : '0;
  assign sw_set     = reg_we && (reg_addr == REG_SWINT) && reg_wdata[0];
  assign ir_out     = (state == ST_REQ);

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_SRC; i++) ack_clr[i] = ack && (irq_id == ID_W'(i));
  end

  // software interrupt sits just above the device lines so it has the lowest priority
  irq_prio_enc #(.N_IN(N_SRC + 1), .ID_W(ID_W)) u_prio_enc (
    .req   ({swpend, pend & mask}),
    .valid (enc_valid),
    .id    (enc_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // edges beat both software clears and the ack clear on the same bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask   <= '0;
      pend   <= '0;
      swpend <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (reg_we && reg_addr == REG_MASK) mask <= reg_wdata[N_SRC-1:0];
      pend   <= (pend & ~w1c & ~ack_clr) | rise;
      swpend <= (swpend & ~(ack && serving_sw)) | sw_set;
      if (timeout) err <= 1'b1;
      else if (reg_we && reg_addr == REG_STATUS) err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ack_cnt   <= '0;
      irq_id    <= '0;
      int_cause <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enc_valid) begin
            irq_id    <= enc_id;
            int_cause <= (enc_id != ID_W'(N_SRC));
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          ack_cnt <= '0;
          state   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (cp0_jump) state <= ST_SERVICE;
          else if (timeout) state <= ST_IDLE;
          else ack_cnt <= ack_cnt + 1'b1;
        end
        default: begin
          if (cp0_eret) state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      REG_MASK:  reg_rdata[N_SRC-1:0] = mask;
      REG_PEND:  reg_rdata[N_SRC-1:0] = pend;
      REG_SWINT: reg_rdata[0] = swpend;
      default: begin
        reg_rdata[STAT_ERR_BIT]          = err;
        reg_rdata[STAT_STATE_LSB +: 2]   = state;
        reg_rdata[STAT_ID_LSB +: ID_W]   = irq_id;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb/tb_irq_source_ctrl.sv - self-checking bench for irq_source_ctrl
module tb_irq_source_ctrl;

  localparam int N_SRC       = 8;
  localparam int ID_W        = 4;
  localparam int ACK_TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_SRC-1:0] irq_src = '0;
  logic             reg_we = 1'b0;
  logic [1:0]       reg_addr = 2'd0;
  logic [31:0]      reg_wdata = '0;
  logic [31:0]      reg_rdata;
  logic             ir_out, int_cause;
  logic [ID_W-1:0]  irq_id;
  logic             cp0_jump = 1'b0;
  logic             cp0_eret = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [N_SRC-1:0] m_pend = '0;
  logic [N_SRC-1:0] m_mask = '0;
  logic             m_sw = 1'b0;

  irq_source_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src   (irq_src),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .ir_out    (ir_out),
    .int_cause (int_cause),
    .irq_id    (irq_id),
    .cp0_jump  (cp0_jump),
    .cp0_eret  (cp0_eret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // lowest enabled pending line, else the software interrupt, else none
  function automatic int exp_id();
    for (int i = 0; i < N_SRC; i++) if (m_pend[i] && m_mask[i]) return i;
    if (m_sw) return N_SRC;
    return -1;
  endfunction

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a;
    #1 d = reg_rdata;
  endtask

  task automatic rd_state(output int st);
    logic [31:0] d;
    rd(2'd3, d);
    st = int'(d[5:4]);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic pulse(input logic [N_SRC-1:0] bits);
    @(negedge clk);
    irq_src = bits;
    @(negedge clk);
    irq_src = '0;
  endtask

  task automatic wait_ir(output bit seen);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ir_out) begin seen = 1; break; end
    end
  endtask

  task automatic ack_now(input int id);
    logic [31:0] d;
    int st;
    cp0_jump = 1'b1;
    @(negedge clk);
    cp0_jump = 1'b0;
    if (id == N_SRC) m_sw = 1'b0; else m_pend[id] = 1'b0;
    rd(2'd1, d);
    check("pend_after_ack", d, 32'(m_pend));
    rd(2'd2, d);
    check("swpend_after_ack", d, 32'(m_sw));
    rd_state(st);
    check("state_service", st, 3);
  endtask

  task automatic eret_now();
    int st;
    cp0_eret = 1'b1;
    @(negedge clk);
    cp0_eret = 1'b0;
    rd_state(st);
    check("state_idle_after_eret", st, 0);
  endtask

  task automatic service_all(input bit allow_sw);
    bit seen;
    int e;
    for (int n = 0; n < 20 && exp_id() >= 0; n++) begin
      e = exp_id();
      wait_ir(seen);
      check("ir_out_seen", 32'(seen), 1);
      if (!seen) break;
      check("irq_id", 32'(irq_id), e);
      check("int_cause", 32'(int_cause), 32'(e != N_SRC));
      @(negedge clk);
      ack_now(e);
      if (allow_sw && e != N_SRC && $urandom_range(0, 2) == 0) begin
        wr(2'd2, 32'd1);
        m_sw = 1'b1;
      end
      eret_now();
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [N_SRC-1:0] bits;
    bit seen;
    int st, cnt, pulses;

    repeat (3) @(negedge clk);
    check("rst_ir_out", 32'(ir_out), 0);
    check("rst_irq_id", 32'(irq_id), 0);
    check("rst_int_cause", 32'(int_cause), 0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check("rst_reg", d, 0);
    end
    rst_n = 1'b1;

    // exact latency for a single-cycle pulse on source 0
    wr(2'd0, 32'h01); m_mask = 8'h01;
    @(negedge clk);
    irq_src = 8'h01;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 0) irq_src = '0;
      check("latency_ir_out", 32'(ir_out), 32'(j == 3));
      if (j == 3) begin
        check("lat_irq_id", 32'(irq_id), 0);
        check("lat_int_cause", 32'(int_cause), 1);
      end
    end
    m_pend = 8'h01;
    ack_now(0);
    eret_now();

    // two simultaneous sources, lower index first
    wr(2'd0, 32'hFF); m_mask = 8'hFF;
    pulse(8'h24); m_pend |= 8'h24;
    service_all(0);

    // masked source pends but never requests; then software interrupt
    wr(2'd0, 32'h00); m_mask = 8'h00;
    pulse(8'h08); m_pend |= 8'h08;
    pulses = 0;
    repeat (5) begin @(negedge clk); if (ir_out) pulses++; end
    check("masked_no_ir", pulses, 0);
    rd(2'd1, d);
    check("masked_pend", d, 32'h08);
    wr(2'd1, 32'h08); m_pend = '0;
    rd(2'd1, d);
    check("w1c_pend", d, 32'h00);
    wr(2'd2, 32'd1); m_sw = 1'b1;
    service_all(0);

    // ack timeout
    wr(2'd0, 32'h10); m_mask = 8'h10;
    pulse(8'h10); m_pend |= 8'h10;
    wait_ir(seen);
    check("to_ir_seen", 32'(seen), 1);
    cnt = 0; st = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rd_state(st);
      if (st == 2) cnt++; else break;
    end
    check("to_state_idle", st, 0);
    check("to_wait_cycles", cnt, ACK_TIMEOUT);
    rd(2'd3, d);
    check("to_err", 32'(d[8]), 1);
    rd(2'd1, d);
    check("to_pend_kept", d, 32'(m_pend));
    @(negedge clk);
    check("to_repulse", 32'(ir_out), 1);
    check("to_repulse_id", 32'(irq_id), 4);
    @(negedge clk);
    ack_now(4);
    eret_now();
    wr(2'd3, 32'd0);
    rd(2'd3, d);
    check("err_cleared", 32'(d[8]), 0);

    // edge on the serviced source lands on the ack edge
    wr(2'd0, 32'h02); m_mask = 8'h02;
    pulse(8'h02); m_pend |= 8'h02;
    wait_ir(seen);
    check("col_ir_seen", 32'(seen), 1);
    check("col_id", 32'(irq_id), 1);
    @(negedge clk);
    irq_src = 8'h02;
    @(negedge clk);
    irq_src = '0;
    @(negedge clk);
    cp0_jump = 1'b1;
    @(negedge clk);
    cp0_jump = 1'b0;
    rd(2'd1, d);
    check("col_repend", d, 32'h02);
    rd_state(st);
    check("col_service", st, 3);
    eret_now();
    service_all(0);

    // randomized rounds against the model
    for (int r = 0; r < 25; r++) begin
      wr(2'd0, 32'h00); m_mask = '0;
      if ($urandom_range(0, 2) == 0) begin
        bits = N_SRC'($urandom);
        wr(2'd1, 32'(bits)); m_pend &= ~bits;
      end
      bits = N_SRC'($urandom);
      pulse(bits); m_pend |= bits;
      pulses = 0;
      repeat (4) begin @(negedge clk); if (ir_out) pulses++; end
      check("rnd_no_ir", pulses, 0);
      rd(2'd1, d);
      check("rnd_pend", d, 32'(m_pend));
      bits = N_SRC'($urandom);
      wr(2'd0, 32'(bits)); m_mask = bits;
      service_all(1);
    end

    // async reset in the middle of WAIT_ACK
    wr(2'd0, 32'h40); m_mask = 8'h40;
    pulse(8'h40); m_pend |= 8'h40;
    wait_ir(seen);
    check("ar_ir_seen", 32'(seen), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ir_out", 32'(ir_out), 0);
    check("ar_irq_id", 32'(irq_id), 0);
    reg_addr = 2'd1;
    #0.5 check("ar_pend", reg_rdata, 0);
    reg_addr = 2'd0;
    #0.5 check("ar_mask", reg_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_pend = '0; m_mask = '0; m_sw = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
